// File: rtl/wm8731_pkg.sv
// wm8731_pkg
// Shared definitions for the WM8731 configuration sequencer:
//   - WM8731 register address constants
//   - the power-up init table, one {7-bit addr, 9-bit data} word per entry
//   - the sequencer state enum
package wm8731_pkg;

  localparam int         NUM_INIT = 11;
  localparam logic [3:0] LAST_IDX = 4'(NUM_INIT - 1);

  localparam logic [6:0] R_LIN    = 7'h00;
  localparam logic [6:0] R_RIN    = 7'h01;
  localparam logic [6:0] R_LHP    = 7'h02;
  localparam logic [6:0] R_RHP    = 7'h03;
  localparam logic [6:0] R_AAP    = 7'h04;
  localparam logic [6:0] R_DAP    = 7'h05;
  localparam logic [6:0] R_PWR    = 7'h06;
  localparam logic [6:0] R_DAIF   = 7'h07;
  localparam logic [6:0] R_SRATE  = 7'h08;
  localparam logic [6:0] R_ACTIVE = 7'h09;
  localparam logic [6:0] R_RESET  = 7'h0F;

  // Codec bring-up order: soft reset, power, line-in/headphone levels, analog
  // and digital paths, I2S 16-bit slave, 48 kHz, and finally activate.
  localparam logic [15:0] INIT_TABLE [NUM_INIT] = '{
    {R_RESET,  9'h000},
    {R_PWR,    9'h000},
    {R_LIN,    9'h017},
    {R_RIN,    9'h017},
    {R_LHP,    9'h079},
    {R_RHP,    9'h079},
    {R_AAP,    9'h012},
    {R_DAP,    9'h000},
    {R_DAIF,   9'h002},
    {R_SRATE,  9'h000},
    {R_ACTIVE, 9'h001}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_DONE,
    S_ERROR,
    S_HOST_ISSUE,
    S_HOST_WAIT
  } state_e;

endpackage

// File: rtl/wm8731_cfg_rom.sv
// wm8731_cfg_rom
// Combinational lookup of one init-table entry by index.
// Ports:
//   idx_i  - table index (0..NUM_INIT-1); out-of-range returns zeros
//   addr_o - WM8731 register address of the entry
//   data_o - 9-bit register data of the entry
module wm8731_cfg_rom
  import wm8731_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [6:0] addr_o,
  output logic [8:0] data_o
);

  logic [15:0] entry;

  // Table lookup; indices past the end read as an all-zero entry.
  always_comb begin
    entry = 16'h0000;
    if (idx_i <= LAST_IDX) begin
      entry = INIT_TABLE[idx_i];
    end
  end

  assign addr_o = entry[15:9];
  assign data_o = entry[8:0];

endmodule

// File: rtl/wm8731_cfg_seq.sv
// wm8731_cfg_seq
// Brings up a WM8731 codec over I2C: after start it waits a power-up delay,
// writes the init table with bounded retry on NACK, then forwards single
// register writes from the host to the shared I2C byte-serialiser.
// Ports:
//   clk, reset            - system clock, async active-high reset
//   start                 - pulse that (re)runs the init sequence
//   host_req/addr/data    - host register write, held until host_ack
//   host_ack/host_nack    - one-cycle completion pulse and its NACK status
//   i2c_req/i2c_wdata     - transfer request and 24-bit word to the I2C master
//   i2c_done/i2c_nack     - transfer-complete pulse and NACK status from it
//   busy/init_done/init_err/err_idx - sequencer status
module wm8731_cfg_seq
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         PWR_DLY   = 50000,
  parameter int         MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        host_req,
  input  logic [6:0]  host_addr,
  input  logic [8:0]  host_data,
  output logic        host_ack,
  output logic        host_nack,
  output logic        i2c_req,
  output logic [23:0] i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [3:0]  err_idx
);

  localparam logic [15:0] DLY_LAST    = 16'(PWR_DLY - 1);
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [2:0]  retryCnt_q;
  logic [15:0] dlyCnt_q;
  logic        i2cReq_q;
  logic [23:0] i2cWdata_q;
  logic        hostAck_q;
  logic        hostNack_q;
  logic        busy_q;
  logic        initDone_q;
  logic        initErr_q;
  logic [3:0]  errIdx_q;

  logic [6:0]  romAddr;
  logic [8:0]  romData;
  logic [2:0]  retryNext;

  wm8731_cfg_rom u_rom (
    .idx_i  (idx_q),
    .addr_o (romAddr),
    .data_o (romData)
  );

  assign retryNext = retryCnt_q + 3'd1;

  // Sequencer: power-up delay, init table walk with retry, then host writes.
  // Every output is a register updated alongside the state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retryCnt_q <= '0;
      dlyCnt_q   <= '0;
      i2cReq_q   <= 1'b0;
      i2cWdata_q <= '0;
      hostAck_q  <= 1'b0;
      hostNack_q <= 1'b0;
      busy_q     <= 1'b0;
      initDone_q <= 1'b0;
      initErr_q  <= 1'b0;
      errIdx_q   <= '0;
    end else begin
      hostAck_q  <= 1'b0;
      hostNack_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q    <= S_PWR_WAIT;
            dlyCnt_q   <= '0;
            idx_q      <= '0;
            retryCnt_q <= '0;
            busy_q     <= 1'b1;
            initDone_q <= 1'b0;
            initErr_q  <= 1'b0;
          // hostAck_q blocks the cycle right after an ack, when the host
          // has not yet had a chance to drop the request it just completed.
          end else if (state_q == S_DONE && host_req && !hostAck_q) begin
            state_q    <= S_HOST_ISSUE;
            busy_q     <= 1'b1;
            initDone_q <= 1'b0;
          end
        end
        S_PWR_WAIT: begin
          if (dlyCnt_q == DLY_LAST) begin
            state_q <= S_INIT_ISSUE;
          end else begin
            dlyCnt_q <= dlyCnt_q + 16'd1;
          end
        end
        S_INIT_ISSUE: begin
          i2cWdata_q <= {DEV_ADDR, 1'b0, romAddr, romData};
          i2cReq_q   <= 1'b1;
          state_q    <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (i2c_done) begin
            i2cReq_q <= 1'b0;
            if (!i2c_nack) begin
              retryCnt_q <= '0;
              if (idx_q == LAST_IDX) begin
                state_q    <= S_DONE;
                busy_q     <= 1'b0;
                initDone_q <= 1'b1;
              end else begin
                idx_q   <= idx_q + 4'd1;
                state_q <= S_INIT_ISSUE;
              end
            end else begin
              retryCnt_q <= retryNext;
              if (retryNext == RETRY_LIMIT) begin
                state_q   <= S_ERROR;
                busy_q    <= 1'b0;
                initErr_q <= 1'b1;
                errIdx_q  <= idx_q;
              end else begin
                state_q <= S_INIT_ISSUE;
              end
            end
          end
        end
        S_HOST_ISSUE: begin
          i2cWdata_q <= {DEV_ADDR, 1'b0, host_addr, host_data};
          i2cReq_q   <= 1'b1;
          state_q    <= S_HOST_WAIT;
        end
        S_HOST_WAIT: begin
          if (i2c_done) begin
            i2cReq_q   <= 1'b0;
            hostAck_q  <= 1'b1;
            hostNack_q <= i2c_nack;
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            initDone_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign host_ack  = hostAck_q;
  assign host_nack = hostNack_q;
  assign i2c_req   = i2cReq_q;
  assign i2c_wdata = i2cWdata_q;
  assign busy      = busy_q;
  assign init_done = initDone_q;
  assign init_err  = initErr_q;
  assign err_idx   = errIdx_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// tb_wm8731_cfg_seq
// Self-checking bench for wm8731_cfg_seq. An I2C master model completes each
// transfer a fixed number of cycles after i2c_req rises and compares the word
// it receives against a queue of expected words pushed by the stimulus.
module tb_wm8731_cfg_seq;

  localparam int PWR_DLY   = 10;
  localparam int MAX_RETRY = 3;
  localparam int XFER_LAT  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        host_req;
  logic [6:0]  host_addr;
  logic [8:0]  host_data;
  logic        host_ack;
  logic        host_nack;
  logic        i2c_req;
  logic [23:0] i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic        busy;
  logic        init_done;
  logic        init_err;
  logic [3:0]  err_idx;

  int compared   = 0;
  int mismatched = 0;

  logic [23:0] expQ [$];
  int          xferCount = 0;
  int          gapCycles = 0;
  int          idleRun   = 0;
  logic        nackAll   = 1'b0;
  logic [23:0] nackWord  = 24'h000000;
  int          nackLeft  = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [8:0]  data;
    logic        nack;
    logic [23:0] expWdata;
    logic        expNack;
  } hostVec_t;

  hostVec_t    hostVecs [5];
  logic [23:0] initWords [11];

  wm8731_cfg_seq #(
    .DEV_ADDR  (7'h1A),
    .PWR_DLY   (PWR_DLY),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .host_req  (host_req),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_ack  (host_ack),
    .host_nack (host_nack),
    .i2c_req   (i2c_req),
    .i2c_wdata (i2c_wdata),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .busy      (busy),
    .init_done (init_done),
    .init_err  (init_err),
    .err_idx   (err_idx)
  );

  // 50 MHz-style free-running clock.
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: actual timeout required event", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pushInit(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      expQ.push_back(initWords[i]);
    end
  endtask

  task automatic waitInit(input string name, input int budget);
    int n;
    n = 0;
    while (!init_done && !init_err && n < budget) begin
      tick();
      n++;
    end
    if (!(init_done || init_err)) timeoutFail(name);
  endtask

  task automatic applyStimulus(input string name, input logic [6:0] a, input logic [8:0] d,
                               input logic expNack, input int budget);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    host_addr = a;
    host_data = d;
    host_req  = 1'b1;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (host_ack) seen = 1'b1;
    end
    host_req = 1'b0;
    if (!seen) begin
      timeoutFail($sformatf("%s_ack", name));
    end else begin
      checkOutput($sformatf("%s_nack", name), host_nack, expNack);
      tick();
      checkOutput($sformatf("%s_ackPulse", name), host_ack, 0);
    end
  endtask

  // I2C master model: accepts a transfer when i2c_req is seen, checks the word
  // against the scoreboard, and pulses i2c_done XFER_LAT cycles later.
  initial begin : i2cModel
    logic        inFlight;
    int          waitCnt;
    logic [23:0] curWord;
    logic [23:0] expWord;
    inFlight = 1'b0;
    waitCnt  = 0;
    curWord  = '0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (reset) begin
        inFlight = 1'b0;
        idleRun  = 0;
      end else if (!inFlight) begin
        if (i2c_req) begin
          inFlight  = 1'b1;
          waitCnt   = 0;
          curWord   = i2c_wdata;
          gapCycles = idleRun;
          xferCount++;
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL xferUnexpected: actual %06h required no transfer", i2c_wdata);
          end else begin
            expWord = expQ.pop_front();
            checkOutput($sformatf("xferWord%0d", xferCount), i2c_wdata, expWord);
          end
        end else begin
          idleRun++;
        end
      end else begin
        waitCnt++;
        if (waitCnt == XFER_LAT) begin
          checkOutput("wdataStable", i2c_wdata, curWord);
          i2c_done = 1'b1;
          if (nackAll) begin
            i2c_nack = 1'b1;
          end else if (curWord == nackWord && nackLeft > 0) begin
            i2c_nack = 1'b1;
            nackLeft--;
          end
          inFlight = 1'b0;
          idleRun  = 0;
        end
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: actual still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin : mainSeq
    int   n;
    int   base;
    int   ackCount;
    int   doneXfers;
    logic seenDone;

    reset     = 1'b1;
    start     = 1'b0;
    host_req  = 1'b0;
    host_addr = '0;
    host_data = '0;

    initWords = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                  24'h340812, 24'h340A00, 24'h340E02, 24'h341000, 24'h341201};
    hostVecs[0] = '{7'h02, 9'h1FF, 1'b0, 24'h3405FF, 1'b0};
    hostVecs[1] = '{7'h02, 9'h1FF, 1'b1, 24'h3405FF, 1'b1};
    hostVecs[2] = '{7'h04, 9'h010, 1'b0, 24'h340810, 1'b0};
    hostVecs[3] = '{7'h0F, 9'h100, 1'b0, 24'h341F00, 1'b0};
    hostVecs[4] = '{7'h7F, 9'h0AA, 1'b1, 24'h34FEAA, 1'b1};

    // Reset state.
    repeat (3) tick();
    checkOutput("rstReq", i2c_req, 0);
    checkOutput("rstWdata", i2c_wdata, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", init_done, 0);
    checkOutput("rstErr", init_err, 0);
    checkOutput("rstErrIdx", err_idx, 0);
    checkOutput("rstAck", host_ack, 0);
    checkOutput("rstNack", host_nack, 0);
    reset = 1'b0;

    // Host request in IDLE is held off.
    host_req = 1'b1; host_addr = 7'h02; host_data = 9'h1FF;
    ackCount = 0;
    repeat (20) begin
      tick();
      if (host_ack) ackCount++;
    end
    host_req = 1'b0;
    checkOutput("idleNoAck", ackCount, 0);
    checkOutput("idleNoXfer", xferCount, 0);
    checkOutput("idleBusy", busy, 0);

    // Nominal init.
    base = xferCount;
    pushInit(0, 10);
    pulseStart();
    checkOutput("pwrBusy", busy, 1);
    checkOutput("pwrReq", i2c_req, 0);
    n = 0;
    while (!i2c_req && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("firstReqLatency", n, 11);
    waitInit("nomInit", 400);
    checkOutput("nomDone", init_done, 1);
    checkOutput("nomErr", init_err, 0);
    checkOutput("nomBusy", busy, 0);
    checkOutput("nomReq", i2c_req, 0);
    checkOutput("nomXfers", xferCount - base, 11);
    checkOutput("nomQEmpty", expQ.size(), 0);
    checkOutput("nomGap", gapCycles, 1);

    // Host writes from DONE, table-driven.
    for (int i = 0; i < 5; i++) begin
      nackAll = hostVecs[i].nack;
      expQ.push_back(hostVecs[i].expWdata);
      applyStimulus($sformatf("host%0d", i), hostVecs[i].addr, hostVecs[i].data,
                    hostVecs[i].expNack, 100);
      checkOutput($sformatf("host%0d_done", i), init_done, 1);
      checkOutput($sformatf("host%0d_qEmpty", i), expQ.size(), 0);
    end
    nackAll = 1'b0;

    // One NACK on index 4 is retried.
    base = xferCount;
    pushInit(0, 4);
    expQ.push_back(initWords[4]);
    pushInit(5, 10);
    nackWord = 24'h340479;
    nackLeft = 1;
    pulseStart();
    waitInit("retryInit", 500);
    checkOutput("retryDone", init_done, 1);
    checkOutput("retryErr", init_err, 0);
    checkOutput("retryXfers", xferCount - base, 12);
    checkOutput("retryQEmpty", expQ.size(), 0);
    checkOutput("retryNackUsed", nackLeft, 0);

    // Host request held through init is served right after the last entry.
    base = xferCount;
    pushInit(0, 10);
    expQ.push_back(24'h3405FF);
    pulseStart();
    host_addr = 7'h02; host_data = 9'h1FF; host_req = 1'b1;
    seenDone = 1'b0; doneXfers = 0; n = 0;
    while (!host_ack && n < 600) begin
      tick();
      n++;
      if (init_done && !seenDone) begin
        seenDone  = 1'b1;
        doneXfers = xferCount - base;
      end
    end
    host_req = 1'b0;
    if (!host_ack) begin
      timeoutFail("heldAck");
    end else begin
      checkOutput("heldSeenDone", seenDone, 1);
      checkOutput("heldXfersAtDone", doneXfers, 11);
      checkOutput("heldXfers", xferCount - base, 12);
      checkOutput("heldGap", gapCycles, 2);
      checkOutput("heldNack", host_nack, 0);
      checkOutput("heldQEmpty", expQ.size(), 0);
    end
    tick();

    // start and host_req in the same DONE cycle: init reruns first.
    base = xferCount;
    pushInit(0, 10);
    expQ.push_back(24'h340810);
    host_addr = 7'h04; host_data = 9'h010; host_req = 1'b1;
    pulseStart();
    checkOutput("bothBusy", busy, 1);
    checkOutput("bothReq", i2c_req, 0);
    checkOutput("bothDone", init_done, 0);
    n = 0;
    while (!host_ack && n < 600) begin
      tick();
      n++;
    end
    host_req = 1'b0;
    if (!host_ack) begin
      timeoutFail("bothAck");
    end else begin
      checkOutput("bothXfers", xferCount - base, 12);
      checkOutput("bothQEmpty", expQ.size(), 0);
    end
    tick();

    // Persistent NACK on index 8 ends in ERROR.
    base = xferCount;
    pushInit(0, 8);
    expQ.push_back(initWords[8]);
    expQ.push_back(initWords[8]);
    nackWord = 24'h340E02;
    nackLeft = 100;
    pulseStart();
    waitInit("errInit", 500);
    checkOutput("errFlag", init_err, 1);
    checkOutput("errIdx", err_idx, 8);
    checkOutput("errDone", init_done, 0);
    checkOutput("errBusy", busy, 0);
    checkOutput("errXfers", xferCount - base, 11);
    checkOutput("errQEmpty", expQ.size(), 0);
    nackLeft = 0;
    host_req = 1'b1; host_addr = 7'h02; host_data = 9'h1FF;
    ackCount = 0;
    repeat (50) begin
      tick();
      if (host_ack) ackCount++;
    end
    host_req = 1'b0;
    checkOutput("errNoAck", ackCount, 0);
    checkOutput("errNoXfer", xferCount - base, 11);
    checkOutput("errStill", init_err, 1);

    // Reset during the index-5 transfer, then a clean replay.
    base = xferCount;
    pushInit(0, 5);
    pulseStart();
    n = 0;
    while (xferCount < base + 6 && n < 400) begin
      tick();
      n++;
    end
    if (xferCount < base + 6) timeoutFail("rstMidReach");
    checkOutput("rstMidReqBefore", i2c_req, 1);
    checkOutput("rstMidWord", i2c_wdata, 24'h340679);
    #5;
    reset = 1'b1;
    #1;
    checkOutput("rstMidReq", i2c_req, 0);
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidWdata", i2c_wdata, 0);
    checkOutput("rstMidErr", init_err, 0);
    checkOutput("rstMidErrIdx", err_idx, 0);
    checkOutput("rstMidDone", init_done, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("rstMidQEmpty", expQ.size(), 0);
    base = xferCount;
    pushInit(0, 10);
    pulseStart();
    waitInit("replayInit", 400);
    checkOutput("replayDone", init_done, 1);
    checkOutput("replayXfers", xferCount - base, 11);
    checkOutput("replayQEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wm8731_cfg_seq.md
Name: wm8731_cfg_seq

Overview:
- Configuration sequencer for the WM8731 codec over I2C. It sits between the codec_avalon register file and the I2C byte-serialiser, which drives i2c_sclk/i2c_sdat.
- After a start pulse it waits a power-up delay, then walks a fixed 11-entry init table and writes each entry to the codec, with bounded retry on NACK.
- Once the table is done it grants single register writes from the host (Avalon side) to the shared I2C master.

Parameters:
- DEV_ADDR, 7'h1A: WM8731 I2C device address (CSB low).
- PWR_DLY, 50000: clk cycles to wait after start before the first write (1 ms at 50 MHz). Legal range 1..65535.
- MAX_RETRY, 3: attempts per init entry before the block flags an error. Legal range 1..7.

Ports:
- clk, in, 1: system clock, 50 MHz.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse that (re)runs the init sequence.
- host_req, in, 1: host write request; held high until host_ack.
- host_addr, in, 7: WM8731 register address.
- host_data, in, 9: WM8731 register data.
- host_ack, out, 1: one-cycle pulse when the host write completes.
- host_nack, out, 1: valid with host_ack; 1 = codec NACKed.
- i2c_req, out, 1: transfer request to the I2C master; held until i2c_done.
- i2c_wdata, out, 24: {DEV_ADDR,1'b0, addr[6:0], data[8], data[7:0]}; stable while i2c_req is high.
- i2c_done, in, 1: one-cycle pulse from the I2C master when the transfer ends.
- i2c_nack, in, 1: sampled with i2c_done; 1 = any byte NACKed.
- busy, out, 1: high in every state except IDLE, DONE and ERROR.
- init_done, out, 1: high in DONE.
- init_err, out, 1: high in ERROR.
- err_idx, out, 4: table index that failed; valid in ERROR.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0; retry counter 0; delay counter 0.
- Init table, index: (addr, data), in this order:
  - 0: (0x0F, 0x000) reset
  - 1: (0x06, 0x000) power
  - 2: (0x00, 0x017)
  - 3: (0x01, 0x017)
  - 4: (0x02, 0x079)
  - 5: (0x03, 0x079)
  - 6: (0x04, 0x012)
  - 7: (0x05, 0x000)
  - 8: (0x07, 0x002) I2S, 16-bit, slave
  - 9: (0x08, 0x000) 48 kHz
  - 10: (0x09, 0x001) active
- State machine:
  - IDLE, DONE, ERROR --start--> PWR_WAIT: clear delay counter, idx and retry counter; drop init_done/init_err.
  - PWR_WAIT: count to PWR_DLY-1, then INIT_ISSUE.
  - INIT_ISSUE: load i2c_wdata from table[idx], assert i2c_req, go to INIT_WAIT.
  - INIT_WAIT on i2c_done: drop i2c_req the same edge, then:
    - nack=0: retry counter cleared. idx==10 -> DONE, else idx++ and INIT_ISSUE.
    - nack=1: retry counter++. If it reaches MAX_RETRY -> ERROR with err_idx=idx, else INIT_ISSUE with the same idx.
  - DONE with host_req=1 and start=0 -> HOST_ISSUE: latch host_addr/host_data, assert i2c_req, go to HOST_WAIT.
  - HOST_WAIT on i2c_done: host_ack=1 for one cycle, host_nack=i2c_nack; return to DONE. No retry on host writes.
- Arbitration:
  - Host writes are served only in DONE.
  - In IDLE, ERROR and all init states host_req is held off: no ack, request stays pending.
  - start and host_req in the same DONE cycle: start wins; host waits for the next DONE.
  - start while busy is ignored. An in-flight transfer is never aborted.
- i2c_req timing: rises exactly one cycle after entering an *_ISSUE state. Minimum gap between consecutive transfers is 1 idle cycle.
- Asynchronous reset mid-transfer returns to IDLE and drops i2c_req immediately. The I2C master is reset by the same signal.
- i2c_done outside the WAIT states is ignored.

Decomposition:
- Shared package wm8731_pkg:
  - register address constants (R_LIN…R_RESET);
  - init table as a constant array of {7-bit addr, 9-bit data};
  - NUM_INIT=11;
  - state enum.
- One sub-module, wm8731_cfg_rom: combinational idx->entry lookup, so the table can be swapped without touching the FSM.

Test Plan:
- Nominal init, PWR_DLY=10, i2c model ACKs every transfer after 5 cycles -> first i2c_req 11 cycles after start. i2c_wdata sequence starts 24'h341E00, 24'h340C00, 24'h340017 and ends 24'h341201. Exactly 11 transfers; init_done=1; busy=0.
- NACK once on idx 4 -> idx 4 sent twice (24'h340479 both times), sequence completes, init_done=1.
- NACK on every try of idx 8, MAX_RETRY=3 -> 3 transfers of 24'h340E02, then init_err=1, err_idx=8, no further i2c_req.
- Host write addr 0x02, data 0x1FF in DONE -> i2c_wdata=24'h3405FF, then one host_ack pulse with host_nack=0. With the model NACKing, the same write gives host_nack=1.
- host_req held during init -> no host_ack until init_done. Host transfer is issued immediately after index 10 completes. start asserted in the same DONE cycle as host_req restarts init first.
- reset asserted during INIT_WAIT of idx 5 -> i2c_req=0 at once, all outputs 0. A following start replays from idx 0.
